// File: rtl/axis_tap_capture.sv
`default_nettype none
// ============================================================================
// Module      : axis_tap_capture
// Description : Capture sequencer behind an AXI-Stream tap. Once armed it
//               forwards whole frames (optionally filtered on tdest) to a
//               monitor port and stops after a frame count or on abort.
//               Frames outside the window are sunk so the tap never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_tap_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [ID_WIDTH-1:0]    s_axis_tid,
  input  logic [DEST_WIDTH-1:0]  s_axis_tdest,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [ID_WIDTH-1:0]    m_axis_tid,
  output logic [DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] frame_count,
  input  logic                   match_enable,
  input  logic [DEST_WIDTH-1:0]  match_dest,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] frames_captured,
  output logic [COUNT_WIDTH-1:0] frames_skipped
);

  localparam int c_beat_w = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] c_one = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_SKIP    = 3'd2,
    S_CAPTURE = 3'd3,
    S_STOP    = 3'd4
  } state_t;

  state_t                  r_state, w_state_n;
  logic                    r_in_frame;
  logic [COUNT_WIDTH-1:0]  r_fc;
  logic                    r_match_en;
  logic [DEST_WIDTH-1:0]   r_match_dest;
  logic                    r_abort_pend;
  logic                    r_skip_cnt;
  logic                    r_done;
  logic [COUNT_WIDTH-1:0]  r_cap, r_skp;
  logic                    r_out_valid, r_skid_valid;
  logic [c_beat_w-1:0]     r_out, r_skid;

  logic                    w_beat, w_sof, w_match, w_limit_hit, w_out_ready;
  logic [COUNT_WIDTH-1:0]  w_cap_next;
  logic [c_beat_w-1:0]     w_in_beat;
  logic                    w_fwd, w_cap_inc, w_skp_inc, w_done_set, w_pend_set;
  logic                    w_skip_load, w_skip_flag, w_arm_start;

  logic [DATA_WIDTH-1:0]   w_o_data;
  logic [KEEP_WIDTH-1:0]   w_o_keep;
  logic                    w_o_last;
  logic [ID_WIDTH-1:0]     w_o_id;
  logic [DEST_WIDTH-1:0]   w_o_dest;
  logic [USER_WIDTH-1:0]   w_o_user;

  // Only CAPTURE/STOP can apply backpressure, and then only from a register.
  assign s_axis_tready = ((r_state == S_CAPTURE) || (r_state == S_STOP)) ? !r_skid_valid : 1'b1;
  assign w_beat        = s_axis_tvalid && s_axis_tready;
  assign w_sof         = !r_in_frame;
  assign w_match       = !r_match_en || (s_axis_tdest == r_match_dest);
  assign w_cap_next    = (r_cap == '1) ? r_cap : r_cap + c_one;
  assign w_limit_hit   = (r_fc != '0) && (w_cap_next == r_fc);
  assign w_arm_start   = (r_state == S_IDLE) && arm;
  assign w_out_ready   = !r_out_valid || m_axis_tready;
  assign w_in_beat     = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

  // Next-state and per-cycle control strobes for the capture window.
  always_comb begin
    w_state_n   = r_state;
    w_fwd       = 1'b0;
    w_cap_inc   = 1'b0;
    w_skp_inc   = 1'b0;
    w_done_set  = 1'b0;
    w_pend_set  = 1'b0;
    w_skip_load = 1'b0;
    w_skip_flag = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_n = S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          w_state_n  = S_IDLE;
          w_done_set = 1'b1;
        end else if (w_beat && w_sof) begin
          if (w_match && !r_skid_valid) begin
            w_fwd = 1'b1;
            if (s_axis_tlast) begin
              w_cap_inc = 1'b1;
              w_state_n = w_limit_hit ? S_STOP : S_ARMED;
            end else begin
              w_state_n = S_CAPTURE;
            end
          end else if (!w_match && s_axis_tlast) begin
            w_skp_inc = 1'b1;
          end else if (!s_axis_tlast) begin
            // A matching frame that finds the skid still occupied is dropped
            // whole rather than truncated; it is not a filter rejection.
            w_state_n   = S_SKIP;
            w_skip_load = 1'b1;
            w_skip_flag = !w_match;
          end
        end
      end
      S_SKIP: begin
        if (abort) w_pend_set = 1'b1;
        if (w_beat && s_axis_tlast) begin
          w_skp_inc = r_skip_cnt;
          if (r_abort_pend || abort) begin
            w_state_n  = S_IDLE;
            w_done_set = 1'b1;
          end else begin
            w_state_n = S_ARMED;
          end
        end
      end
      S_CAPTURE: begin
        if (abort) w_pend_set = 1'b1;
        if (w_beat) begin
          w_fwd = 1'b1;
          if (s_axis_tlast) begin
            w_cap_inc = 1'b1;
            w_state_n = (r_abort_pend || abort || w_limit_hit) ? S_STOP : S_ARMED;
          end
        end
      end
      S_STOP: begin
        if (!r_out_valid && !r_skid_valid) begin
          w_state_n  = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register, source framing tracker, configuration and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_frame   <= 1'b0;
      r_fc         <= '0;
      r_match_en   <= 1'b0;
      r_match_dest <= '0;
      r_abort_pend <= 1'b0;
      r_skip_cnt   <= 1'b0;
      r_done       <= 1'b0;
      r_cap        <= '0;
      r_skp        <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_beat) r_in_frame <= !s_axis_tlast;
      if (w_skip_load) r_skip_cnt <= w_skip_flag;
      if (w_arm_start) begin
        r_fc         <= frame_count;
        r_match_en   <= match_enable;
        r_match_dest <= match_dest;
        r_cap        <= '0;
        r_skp        <= '0;
        r_done       <= 1'b0;
        r_abort_pend <= 1'b0;
      end else begin
        if (w_cap_inc) r_cap <= w_cap_next;
        if (w_skp_inc && (r_skp != '1)) r_skp <= r_skp + c_one;
        if (w_done_set) begin
          r_done       <= 1'b1;
          r_abort_pend <= 1'b0;
        end else if (w_pend_set) begin
          r_abort_pend <= 1'b1;
        end
      end
    end
  end

  // Output register plus one skid entry; the skid absorbs the beat accepted
  // while the output is stalled, so tready never depends on m_axis_tready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (w_out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_fwd;
        if (w_fwd) r_out <= w_in_beat;
      end
    end else if (w_fwd) begin
      r_skid       <= w_in_beat;
      r_skid_valid <= 1'b1;
    end
  end

  assign {w_o_data, w_o_keep, w_o_last, w_o_id, w_o_dest, w_o_user} = r_out;

  assign m_axis_tvalid   = r_out_valid;
  assign m_axis_tdata    = w_o_data;
  assign m_axis_tlast    = w_o_last;
  assign m_axis_tkeep    = (KEEP_ENABLE != 0) ? w_o_keep : '1;
  assign m_axis_tid      = (ID_ENABLE   != 0) ? w_o_id   : '0;
  assign m_axis_tdest    = (DEST_ENABLE != 0) ? w_o_dest : '0;
  assign m_axis_tuser    = (USER_ENABLE != 0) ? w_o_user : '0;

  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign frames_captured = r_cap;
  assign frames_skipped  = r_skp;

endmodule
`default_nettype wire

// File: tb/tb_axis_tap_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_tap_capture
// Description : Self-checking bench for axis_tap_capture. Frames are built
//               with random payload, a frame-level reference model derives
//               the expected captured stream and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_tap_capture;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] dest;
    logic       user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic [0:0] s_tkeep = 1'b1;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] s_tid = '0;
  logic [7:0] s_tdest = '0;
  logic [0:0] s_tuser = '0;
  logic [7:0] m_tdata;
  logic [0:0] m_tkeep;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast;
  logic [7:0] m_tid;
  logic [7:0] m_tdest;
  logic [0:0] m_tuser;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_count = '0;
  logic       match_enable = 1'b0;
  logic [7:0] match_dest = '0;
  logic       busy, done;
  logic [7:0] frames_captured, frames_skipped;

  axis_tap_capture #(
    .DATA_WIDTH(8), .ID_ENABLE(0), .ID_WIDTH(8), .DEST_ENABLE(1), .DEST_WIDTH(8),
    .USER_ENABLE(1), .USER_WIDTH(1), .COUNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .arm(arm), .abort(abort), .frame_count(frame_count),
    .match_enable(match_enable), .match_dest(match_dest),
    .busy(busy), .done(done),
    .frames_captured(frames_captured), .frames_skipped(frames_skipped)
  );

  always #5 clk = ~clk;

  beat_t stim_q[$];
  beat_t exp_q[$];
  beat_t out_q[$];
  int    out_cyc[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    tready_viol = 0;
  int    side_viol = 0;
  int    stalls = 0;
  int    exp_cap = 0;
  int    exp_skp = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_tready <= 1'($urandom);
      2:       m_tready <= 1'b0;
      default: m_tready <= 1'b1;
    endcase
  end

  // Monitor on the inactive edge: record transfers and property violations.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      out_q.push_back('{data: m_tdata, last: m_tlast, dest: m_tdest, user: m_tuser[0]});
      out_cyc.push_back(cyc);
    end
    if (!rst && !busy && !s_tready) tready_viol++;
    if (m_tvalid && (m_tkeep !== 1'b1 || m_tid !== 8'h00)) side_viol++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input int len, input logic [7:0] dest);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      b.last = (k == len - 1);
      b.dest = dest;
      b.user = 1'($urandom);
      stim_q.push_back(b);
    end
  endtask

  // Frame-level reference: whole frames only, filter on first-beat dest,
  // stop after frame_count captures, saturating 8-bit counters.
  task automatic model(input int fc, input bit men, input logic [7:0] md, input bit starts_mid);
    beat_t fb[$];
    bit    mid = starts_mid;
    bit    stopped = 0;
    exp_q.delete();
    exp_cap = 0;
    exp_skp = 0;
    foreach (stim_q[i]) begin
      fb.push_back(stim_q[i]);
      if (stim_q[i].last) begin
        if (mid) mid = 0;
        else if (!stopped) begin
          if (!men || fb[0].dest == md) begin
            foreach (fb[j]) exp_q.push_back(fb[j]);
            if (exp_cap < 255) exp_cap++;
            if (fc != 0 && exp_cap == fc) stopped = 1;
          end else if (exp_skp < 255) begin
            exp_skp++;
          end
        end
        fb.delete();
      end
    end
  endtask

  task automatic send_beat(input beat_t b, input bit do_arm, input bit do_abort);
    int n = 0;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = b.data;
    s_tlast  = b.last;
    s_tdest  = b.dest;
    s_tuser  = b.user;
    arm      = do_arm;
    abort    = do_abort;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      arm   = 1'b0;
      abort = 1'b0;
      stalls++;
      n++;
    end
    if (n >= 200) chk("src_timeout", 32'(s_tready), 32'd1);
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    s_tvalid = 1'b0;
    arm      = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_out_empty();
    int n = 0;
    while (m_tvalid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 32'(m_tvalid), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) begin
      send_beat(stim_q[i], 1'b0, 1'b0);
      if (gap && stim_q[i].last) begin
        go_idle();
        wait_out_empty();
      end
    end
    go_idle();
  endtask

  task automatic pulse_arm(input int fc, input bit men, input logic [7:0] md);
    @(negedge clk);
    frame_count  = 8'(fc);
    match_enable = men;
    match_dest   = md;
    s_tvalid     = 1'b0;
    arm          = 1'b1;
    @(negedge clk);
    arm          = 1'b0;
  endtask

  task automatic close_window(input bit use_abort);
    go_idle();
    wait_out_empty();
    if (use_abort && busy) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_idle();
    chk("done_at_close", 32'(done), 32'd1);
    chk("busy_at_close", 32'(busy), 32'd0);
  endtask

  task automatic check_results(input string tag);
    int n;
    chk({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    chk({tag, "_captured"}, 32'(frames_captured), 32'(exp_cap));
    chk({tag, "_skipped"}, 32'(frames_skipped), 32'(exp_skp));
  endtask

  initial begin
    int st0, idx0, fc;
    beat_t a0, a1;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_captured", 32'(frames_captured), 32'd0);
    chk("rst_skipped", 32'(frames_skipped), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);

    // 1: frame_count=2, four 3-beat frames, no filter
    stim_q.delete(); out_q.delete();
    for (int f = 0; f < 4; f++) make_frame(3, 8'(f));
    model(2, 0, 8'd0, 0);
    pulse_arm(2, 0, 8'd0);
    send_range(0, stim_q.size(), 0);
    close_window(0);
    check_results("t1");

    // 2: arm coincides with beat 2 of a 4-beat frame
    stim_q.delete(); out_q.delete();
    make_frame(4, 8'd1);
    a0 = stim_q.pop_front();
    a1 = stim_q.pop_front();
    make_frame(3, 8'd2);
    make_frame(2, 8'd3);
    model(1, 0, 8'd0, 1);
    @(negedge clk);
    frame_count = 8'd1; match_enable = 1'b0;
    send_beat(a0, 1'b0, 1'b0);
    send_beat(a1, 1'b1, 1'b0);
    send_range(0, stim_q.size(), 0);
    close_window(0);
    check_results("t2");

    // 3: tdest filter, dests 3,5,3,5, frame_count=2
    stim_q.delete(); out_q.delete();
    make_frame(int'($urandom_range(1, 4)), 8'd3);
    make_frame(int'($urandom_range(1, 4)), 8'd5);
    make_frame(int'($urandom_range(1, 4)), 8'd3);
    make_frame(int'($urandom_range(1, 4)), 8'd5);
    model(2, 1, 8'd5, 0);
    pulse_arm(2, 1, 8'd5);
    send_range(0, stim_q.size(), 0);
    close_window(0);
    check_results("t3");

    // 4: unlimited count, abort during beat 2 of a 5-beat frame
    stim_q.delete(); out_q.delete();
    make_frame(5, 8'd7);
    model(0, 0, 8'd0, 0);
    pulse_arm(0, 0, 8'd0);
    for (int i = 0; i < 5; i++) send_beat(stim_q[i], 1'b0, i == 1);
    go_idle();
    wait_out_empty();
    wait_idle();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    check_results("t4");

    // 5: 64-beat frame with random ready, then 64 beats with ready held
    stim_q.delete(); out_q.delete(); out_cyc.delete();
    make_frame(64, 8'd9);
    make_frame(64, 8'd9);
    model(0, 0, 8'd0, 0);
    pulse_arm(0, 0, 8'd0);
    rdy_mode = 1;
    send_range(0, 64, 0);
    wait_out_empty();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    st0  = stalls;
    idx0 = out_q.size();
    send_range(64, 128, 0);
    wait_out_empty();
    chk("t5_full_rate_stalls", 32'(stalls - st0), 32'd0);
    if (out_cyc.size() >= idx0 + 64)
      chk("t5_out_contiguous", 32'(out_cyc[idx0 + 63] - out_cyc[idx0]), 32'd63);
    else
      chk("t5_out_count", 32'(out_cyc.size() - idx0), 32'd64);
    close_window(1);
    check_results("t5");
    chk("t5_tready_outside_window", 32'(tready_viol), 32'd0);

    // 6: reset in the middle of a capture
    stim_q.delete(); out_q.delete();
    make_frame(2, 8'd1);
    make_frame(6, 8'd1);
    pulse_arm(0, 0, 8'd0);
    send_range(0, 2, 0);
    wait_out_empty();
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    send_beat(stim_q[2], 1'b0, 1'b0);
    send_beat(stim_q[3], 1'b0, 1'b0);
    go_idle();
    chk("t6_pre_tvalid", 32'(m_tvalid), 32'd1);
    chk("t6_pre_captured", 32'(frames_captured), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_captured", 32'(frames_captured), 32'd0);
    chk("t6_rst_skipped", 32'(frames_skipped), 32'd0);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    stim_q.delete(); out_q.delete();
    make_frame(3, 8'd4);
    make_frame(2, 8'd4);
    model(1, 0, 8'd0, 0);
    pulse_arm(1, 0, 8'd0);
    send_range(0, stim_q.size(), 0);
    close_window(0);
    check_results("t6");

    // 7: captured counter saturates at all-ones
    stim_q.delete(); out_q.delete();
    for (int f = 0; f < 260; f++) make_frame(1, 8'(f));
    model(0, 0, 8'd0, 0);
    pulse_arm(0, 0, 8'd0);
    send_range(0, stim_q.size(), 0);
    close_window(1);
    check_results("t7");

    // 8: random frames, filter on dest 5, random count and ready
    for (int r = 0; r < 3; r++) begin
      stim_q.delete(); out_q.delete();
      fc = int'($urandom_range(0, 3));
      for (int f = 0; f < 10; f++)
        make_frame(int'($urandom_range(1, 4)), ($urandom_range(0, 1) != 0) ? 8'd5 : 8'd3);
      model(fc, 1, 8'd5, 0);
      pulse_arm(fc, 1, 8'd5);
      rdy_mode = 1;
      send_range(0, stim_q.size(), 1);
      rdy_mode = 0;
      close_window(1);
      check_results($sformatf("t8_r%0d", r));
    end

    chk("tready_outside_window", 32'(tready_viol), 32'd0);
    chk("sideband_constants", 32'(side_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
